button_in: RTL
==============

# button_in

Debounced pushbutton input stage for the board's user buttons. It is the input-side counterpart of the LED blinkers: it takes a raw, bouncing, asynchronous pin, synchronises it into `clk`, and filters it. It then produces a clean level, single-cycle press/release/long-press events, and a press counter for the LED logic to consume. One instance sits per physical button in the top level.

## Interface
- `DEBOUNCE`, default 16: consecutive stable cycles required to accept a new level. Must be ≥ 2.
- `LONG_PRESS`, default 1000: cycles the button must stay pressed (after acceptance) before a long-press event. Must be ≥ 1.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed; 0 means the pin reads 1 when pressed.
- `clk` input, 1 bit: single system clock. All logic is on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `btn` input, 1 bit: raw pad, asynchronous to `clk`.
- `pressed` output, 1 bit: debounced level, 1 while the button is held.
- `press_pulse` output, 1 bit: one-cycle strobe on an accepted press.
- `release_pulse` output, 1 bit: one-cycle strobe on an accepted release.
- `long_pulse` output, 1 bit: one-cycle strobe when a press reaches `LONG_PRESS`.
- `press_count` output, 8 bits: number of accepted presses, modulo 256.

## Operation
- **Normalisation.** `btn` is XORed with `ACTIVE_LOW` to form `raw`, so `raw` is 1 when the button is pressed. `raw` then passes through a 2-flop synchroniser to give `s`. Both flops reset to 0 (released).
- **Debounce.**
  - Counter `dcnt` has width clog2(`DEBOUNCE`).
  - If `s == pressed`, `dcnt` is cleared.
  - Otherwise `dcnt` increments. When `dcnt == DEBOUNCE-1` and `s != pressed`, `pressed` toggles and `dcnt` clears.
  - Any cycle with `s == pressed` restarts the count, so glitches shorter than `DEBOUNCE` cycles are discarded.
- **Events.** `press_pulse` and `release_pulse` are registered and assert in the same cycle that `pressed` changes. They are never asserted together.
- **Press counter.** `press_count` increments by 1 in the cycle `press_pulse` is high. It wraps 255 → 0.
- **State machine** (states IDLE, DOWN, HELD):
  - IDLE → DOWN on an accepted press; the long counter `lcnt` clears.
  - DOWN: `lcnt` increments each cycle. When `lcnt == LONG_PRESS-1`, `long_pulse` is high for the next cycle and the state moves to HELD.
  - DOWN → IDLE or HELD → IDLE on an accepted release.
  - HELD: `lcnt` frozen, no further `long_pulse`.
  - Release and long-press terminal count in the same cycle: release wins, and no `long_pulse` is issued.
  - `lcnt` width is clog2(`LONG_PRESS`+1). It never wraps.

## Timing
- **Reset.** On `rst_n` low, all outputs go to 0 immediately (asynchronous): `pressed`, all pulses, and `press_count`. Synchroniser, `dcnt`, `lcnt` and state (IDLE) also clear. Reset mid-press discards the press in progress; no release event follows.
- **Press latency.** Pin change to `pressed`/`press_pulse` is 2 synchroniser cycles + `DEBOUNCE` cycles, with the pin held stable throughout.
- **Release latency.** Identical to press latency.
- **Long-press latency.** `long_pulse` asserts exactly `LONG_PRESS` cycles after the `press_pulse` cycle.
- **Pulse width.** Every pulse is exactly 1 cycle.
- **Counter latency.** `press_count` updates 1 cycle after `press_pulse`, i.e. it is registered on the same edge that ends the pulse.
- **After reset.** Pin held pressed through reset release gives `press_pulse` at 2+`DEBOUNCE` cycles after `rst_n` rises.

## Configuration
- Macro: `BUTTON_LONG_PRESS_EN`.
- Defined: the DOWN/HELD state machine and `lcnt` are built, and `long_pulse` behaves as above.
- Undefined: no state machine, `lcnt` or `LONG_PRESS` logic is generated. `long_pulse` is tied to 0. `LONG_PRESS` is accepted but ignored. All other behaviour and timing are unchanged.

## Test plan
All cases use `DEBOUNCE`=4, `LONG_PRESS`=20, `ACTIVE_LOW`=1.
- **Clean press.** `btn` falls before edge 10 and stays low → `pressed` and `press_pulse` high at cycle 16. Pulse lasts 1 cycle. `press_count` = 1 at cycle 17.
- **Bounce rejection.** `btn` low for 3 cycles, then high 1 cycle, then low 3 cycles, then high → `pressed` stays 0; no pulses.
- **Release.** Press accepted, then `btn` rises at cycle 40 → `pressed` = 0 and `release_pulse` = 1 at cycle 46.
- **Long press** (macro defined). Button held 50 cycles after acceptance → exactly one `long_pulse`, 20 cycles after `press_pulse`. The same stimulus with the macro undefined → `long_pulse` never asserts.
- **Counter wrap.** 256 clean press/release pairs → `press_count` reads 255, then 0.
- **Reset mid-press.** `rst_n` low while `pressed` = 1 → all outputs 0 in the same cycle, with no `release_pulse`. `rst_n` high with `btn` held low → `press_pulse` 6 cycles later and `press_count` = 1.

Source files
------------

// File: rtl/button_in.sv
// button_in: synchronised, debounced pushbutton with press/release/long-press strobes and press counter.
// Define BUTTON_LONG_PRESS_EN to build the long-press state machine; otherwise long_pulse is tied to 0.
module button_in #(
  parameter int DEBOUNCE   = 16,
  parameter int LONG_PRESS = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE);
  if (DEBOUNCE < 2 || LONG_PRESS < 1) begin : g_bad_params
    $error("button_in: DEBOUNCE must be >= 2 and LONG_PRESS >= 1");
  end
  logic          raw, s1, s, flip;
  logic [DW-1:0] dcnt;
  assign raw  = btn ^ ACTIVE_LOW;
  assign flip = (s != pressed) && (dcnt == DW'(DEBOUNCE - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1            <= 1'b0;
      s             <= 1'b0;
      dcnt          <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      s1            <= raw;
      s             <= s1;
      dcnt          <= (s == pressed || flip) ? '0 : dcnt + 1'b1;
      pressed       <= flip ? ~pressed : pressed;
      press_pulse   <= flip & ~pressed;
      release_pulse <= flip & pressed;
      press_count   <= press_pulse ? press_count + 8'd1 : press_count;
    end
`ifdef BUTTON_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS + 1);
  typedef enum logic [1:0] {IDLE, DOWN, HELD} state_t;
  state_t        state, state_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic          long_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      lcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      lcnt       <= lcnt_n;
      long_pulse <= long_n;
    end
  // a release on the terminal-count cycle takes priority over the long-press strobe
  always_comb begin
    state_n = state;
    lcnt_n  = lcnt;
    long_n  = 1'b0;
    case (state)
      IDLE: if (flip && !pressed) begin
        state_n = DOWN;
        lcnt_n  = '0;
      end
      DOWN: if (flip) state_n = IDLE;
        else if (lcnt == LW'(LONG_PRESS - 1)) begin
          state_n = HELD;
          long_n  = 1'b1;
        end else lcnt_n = lcnt + 1'b1;
      HELD: state_n = flip ? IDLE : HELD;
      default: state_n = IDLE;
    endcase
  end
`else
  assign long_pulse = 1'b0;
`endif
endmodule
